// File: rtl/if_line_buffer_pkg.sv
// Shared widths, reset level and FSM encoding for the instruction-fetch line buffer.
package if_line_buffer_pkg;

  localparam int   DataBus_WIDTH = 64;
  localparam int   InstBus_WIDTH = 32;
  localparam logic RestEnable    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } lb_state_e;

  // Pick the 32-bit instruction word out of an 8-byte line using pc[2].
  function automatic logic [InstBus_WIDTH-1:0] sel_word(
    input logic [DataBus_WIDTH-1:0] line,
    input logic                     hi
  );
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/if_line_buffer.sv
// Instruction-fetch line buffer: one 8-byte line in front of the IRAM read channels.
// LB_LINE_BUF_EN builds the line register and hit path; without it every aligned fetch reads IRAM.
module if_line_buffer
  import if_line_buffer_pkg::*;
(
  input  logic                     lb_clk_i,
  input  logic                     lb_rst_n_i,
  input  logic                     lb_req_valid_i,
  output logic                     lb_req_ready_o,
  input  logic [DataBus_WIDTH-1:0] lb_req_pc_i,
  input  logic                     lb_flush_i,
  output logic                     lb_inst_valid_o,
  input  logic                     lb_inst_ready_i,
  output logic [InstBus_WIDTH-1:0] lb_inst_o,
  output logic [DataBus_WIDTH-1:0] lb_inst_pc_o,
  output logic                     lb_inst_err_o,
  output logic                     lb_ar_valid_o,
  input  logic                     lb_ar_ready_i,
  output logic [DataBus_WIDTH-1:0] lb_ar_addr_o,
  input  logic                     lb_r_valid_i,
  output logic                     lb_r_ready_o,
  input  logic [DataBus_WIDTH-1:0] lb_r_data_i,
  input  logic                     lb_r_err_i
);

  lb_state_e                r_state;
  logic                     r_req_ready;
  logic                     r_ar_valid;
  logic                     r_r_ready;
  logic                     r_inst_valid;
  logic                     r_inst_err;
  logic                     r_drop;
  logic [DataBus_WIDTH-1:0] r_ar_addr;
  logic [DataBus_WIDTH-1:0] r_inst_pc;
  logic [InstBus_WIDTH-1:0] r_inst;

  logic                     w_req_fire;
  logic                     w_r_fire;
  logic                     w_misalign;
  logic                     w_hit;
  logic [InstBus_WIDTH-1:0] w_hit_inst;

  assign w_req_fire = lb_req_valid_i && r_req_ready;
  assign w_r_fire   = lb_r_valid_i && r_r_ready;
  assign w_misalign = |lb_req_pc_i[1:0];

`ifdef LB_LINE_BUF_EN
  logic [DataBus_WIDTH-1:0] r_line;
  logic [DataBus_WIDTH-1:3] r_tag;
  logic                     r_line_vld;

  assign w_hit      = r_line_vld && (r_tag == lb_req_pc_i[DataBus_WIDTH-1:3]);
  assign w_hit_inst = sel_word(r_line, lb_req_pc_i[2]);

  // Fills happen even for flushed fetches; a faulting read invalidates the line.
  always_ff @(posedge lb_clk_i or negedge lb_rst_n_i) begin
    if (lb_rst_n_i == RestEnable) begin
      r_line_vld <= 1'b0;
      r_line     <= '0;
      r_tag      <= '0;
    end else if (w_r_fire) begin
      if (lb_r_err_i) begin
        r_line_vld <= 1'b0;
      end else begin
        r_line_vld <= 1'b1;
        r_line     <= lb_r_data_i;
        r_tag      <= r_inst_pc[DataBus_WIDTH-1:3];
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = '0;
`endif

  always_ff @(posedge lb_clk_i or negedge lb_rst_n_i) begin
    if (lb_rst_n_i == RestEnable) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_ar_valid   <= 1'b0;
      r_r_ready    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_err   <= 1'b0;
      r_drop       <= 1'b0;
      r_ar_addr    <= '0;
      r_inst_pc    <= '0;
      r_inst       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            r_inst_pc   <= lb_req_pc_i;
            if (w_misalign) begin
              r_state      <= S_RESP;
              r_inst_valid <= 1'b1;
              r_inst       <= '0;
              r_inst_err   <= 1'b1;
            end else if (w_hit) begin
              r_state      <= S_RESP;
              r_inst_valid <= 1'b1;
              r_inst       <= w_hit_inst;
              r_inst_err   <= 1'b0;
            end else begin
              r_state    <= S_AR;
              r_ar_valid <= 1'b1;
              r_ar_addr  <= {lb_req_pc_i[DataBus_WIDTH-1:3], 3'b000};
            end
          end
        end
        // The address must still be handed over after a flush so IRAM sees a complete transaction.
        S_AR: begin
          if (lb_flush_i) r_drop <= 1'b1;
          if (lb_ar_ready_i) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_R;
          end
        end
        S_R: begin
          if (w_r_fire) begin
            r_r_ready <= 1'b0;
            if (r_drop || lb_flush_i) begin
              r_drop      <= 1'b0;
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_state      <= S_RESP;
              r_inst_valid <= 1'b1;
              r_inst_err   <= lb_r_err_i;
              r_inst       <= lb_r_err_i ? '0 : sel_word(lb_r_data_i, r_inst_pc[2]);
            end
          end else if (lb_flush_i) begin
            r_drop <= 1'b1;
          end
        end
        S_RESP: begin
          if (lb_flush_i || lb_inst_ready_i) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lb_req_ready_o  = r_req_ready;
  // A flush kills the presented instruction in the same cycle.
  assign lb_inst_valid_o = r_inst_valid && !lb_flush_i;
  assign lb_inst_o       = r_inst;
  assign lb_inst_pc_o    = r_inst_pc;
  assign lb_inst_err_o   = r_inst_err;
  assign lb_ar_valid_o   = r_ar_valid;
  assign lb_ar_addr_o    = r_ar_addr;
  assign lb_r_ready_o    = r_r_ready;

endmodule

// File: tb/tb_if_line_buffer.sv
// Randomized bench for if_line_buffer: the bench plays IRAM and decode and predicts each fetch
// from a transaction-level model of the single cached line.
module tb_if_line_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_pc = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [63:0] ar_addr;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_data = '0;
  logic        r_err = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // Reference view of the line: what the last completed IRAM read left behind.
  logic        m_vld = 1'b0;
  logic [63:0] m_line = '0;
  logic [60:0] m_tag = '0;

  if_line_buffer dut (
    .lb_clk_i       (clk),
    .lb_rst_n_i     (rst_n),
    .lb_req_valid_i (req_valid),
    .lb_req_ready_o (req_ready),
    .lb_req_pc_i    (req_pc),
    .lb_flush_i     (flush),
    .lb_inst_valid_o(inst_valid),
    .lb_inst_ready_i(inst_ready),
    .lb_inst_o      (inst),
    .lb_inst_pc_o   (inst_pc),
    .lb_inst_err_o  (inst_err),
    .lb_ar_valid_o  (ar_valid),
    .lb_ar_ready_i  (ar_ready),
    .lb_ar_addr_o   (ar_addr),
    .lb_r_valid_i   (r_valid),
    .lb_r_ready_o   (r_ready),
    .lb_r_data_i    (r_data),
    .lb_r_err_i     (r_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_ar_valid"}, 64'(ar_valid), 64'd0);
    chk({tag, "_r_ready"}, 64'(r_ready), 64'd0);
    chk({tag, "_ar_addr"}, ar_addr, 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_inst_pc"}, inst_pc, 64'd0);
    chk({tag, "_inst_err"}, 64'(inst_err), 64'd0);
  endtask

  // One fetch from request to return-to-idle. flush_at: cycle after acceptance to pulse flush (0 = none).
  task automatic run_txn(input logic [63:0] pc, input logic [63:0] data, input logic rerr,
                         input int flush_at, input int ar_dly, input int r_dly, input int i_dly);
    logic        exp_mem, exp_err, flushed, got_inst, ar_pend, done;
    logic [31:0] exp_inst;
    logic [63:0] sh;
    int          n_ar, n_r, aw, rw, iw, w;
    exp_mem = (pc[1:0] == 2'b00);
    exp_err = !exp_mem;
    exp_inst = '0;
    if (exp_mem) begin
      sh = pc[2] ? (data >> 32) : data;
      exp_inst = rerr ? 32'd0 : sh[31:0];
      exp_err = rerr;
    end
`ifdef LB_LINE_BUF_EN
    if (exp_mem && m_vld && m_tag == pc[63:3]) begin
      exp_mem = 1'b0;
      sh = pc[2] ? (m_line >> 32) : m_line;
      exp_inst = sh[31:0];
      exp_err = 1'b0;
    end
`endif
    aw = ar_dly; rw = r_dly; iw = i_dly;
    n_ar = 0; n_r = 0; flushed = 0; got_inst = 0; ar_pend = 0; done = 0;

    @(negedge clk);
    req_valid = 1'b1;
    req_pc = pc;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);

    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      flush = (k == flush_at);
      #1;
      if (req_ready) begin
        done = 1;
      end else begin
        if (flush) flushed = 1;
        if (ar_pend) chk("ar_hold", 64'(ar_valid), 64'd1);
        if (ar_valid) begin
          chk("ar_addr", ar_addr, {pc[63:3], 3'b000});
          if (aw == 0) begin ar_ready = 1'b1; n_ar++; ar_pend = 0; end
          else begin aw--; ar_ready = 1'b0; ar_pend = 1; end
        end else ar_ready = 1'b0;
        if (r_ready) begin
          if (rw == 0) begin
            r_valid = 1'b1; r_data = data; r_err = rerr; n_r++;
            if (!rerr) begin m_vld = 1'b1; m_line = data; m_tag = pc[63:3]; end
            else m_vld = 1'b0;
          end else begin rw--; r_valid = 1'b0; end
        end else r_valid = 1'b0;
        if (inst_valid) begin
          chk("inst_after_flush", 64'(flushed), 64'd0);
          chk("inst", 64'(inst), 64'(exp_inst));
          chk("inst_err", 64'(inst_err), 64'(exp_err));
          chk("inst_pc", inst_pc, pc);
          if (iw == 0) begin inst_ready = 1'b1; got_inst = 1; end
          else begin iw--; inst_ready = 1'b0; end
        end else inst_ready = 1'b0;
      end
    end
    flush = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; inst_ready = 1'b0;
    chk("txn_done", 64'(done), 64'd1);
    chk("mem_reads", 64'(n_ar), 64'(exp_mem));
    chk("r_beats", 64'(n_r), 64'(exp_mem));
    chk("delivered", 64'(got_inst), 64'(!flushed));
  endtask

  localparam logic [63:0] D0 = 64'h00000013_00100093;

  initial begin
    #12;
    chk_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(64'h8000_0000, D0, 1'b0, 0, 0, 1, 2);
    run_txn(64'h8000_0004, D0, 1'b0, 0, 0, 0, 0);
    run_txn(64'h8000_0002, D0, 1'b0, 0, 0, 0, 0);
    run_txn(64'h8000_1000, 64'h1111_2222_3333_4444, 1'b0, 2, 3, 0, 0);
    run_txn(64'h8000_2000, 64'hdead_beef_cafe_f00d, 1'b1, 0, 0, 1, 1);
    run_txn(64'h8000_2000, 64'h0123_4567_89ab_cdef, 1'b0, 0, 1, 0, 0);
    run_txn(64'h8000_3000, 64'h5555_6666_7777_8888, 1'b0, 2, 0, 0, 0);
    run_txn(64'h8000_3004, 64'h9999_aaaa_bbbb_cccc, 1'b0, 0, 0, 0, 0);
    run_txn(64'h8000_3001, D0, 1'b0, 2, 0, 0, 3);

    // Reset while a miss waits on the address channel.
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = 64'h8000_4000;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("ar_pending", 64'(ar_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    m_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(64'h8000_3004, 64'h0f0f_0f0f_f0f0_f0f0, 1'b0, 0, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      logic [63:0] pc;
      pc = 64'h8000_0000 | 64'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 2));
      if ($urandom_range(0, 7) == 0) pc = pc | 64'($urandom_range(1, 3));
      run_txn(pc, {$urandom, $urandom}, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/if_line_buffer.md
IF_LINE_BUFFER -- requirements
Module: if_line_buffer

Interface
REQ-001 SHALL have port lb_clk_i, input, 1, single clock, all state on rising edge.
REQ-002 SHALL have port lb_rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port lb_req_valid_i, input, 1, fetch request from PC stage.
REQ-004 SHALL have port lb_req_ready_o, output, 1, request accepted when valid and ready.
REQ-005 SHALL have port lb_req_pc_i, input, 64 (DataBus_WIDTH), fetch PC.
REQ-006 SHALL have port lb_flush_i, input, 1, branch/trap redirect; kill in-flight fetch.
REQ-007 SHALL have ports lb_inst_valid_o (output, 1) and lb_inst_ready_i (input, 1), instruction handshake to decode.
REQ-008 SHALL have ports lb_inst_o (output, 32, InstBus_WIDTH), lb_inst_pc_o (output, 64), lb_inst_err_o (output, 1, fetch fault).
REQ-009 SHALL have ports lb_ar_valid_o (output, 1), lb_ar_ready_i (input, 1), lb_ar_addr_o (output, 64), IRAM read-address channel.
REQ-010 SHALL have ports lb_r_valid_i (input, 1), lb_r_ready_o (output, 1), lb_r_data_i (input, 64), lb_r_err_i (input, 1), IRAM read-data channel.

Function
REQ-011 SHALL implement FSM states IDLE, AR, R, RESP; lb_req_ready_o high only in IDLE.
REQ-012 SHALL hold one 64-bit line register, tag = pc[63:3], valid bit.
REQ-013 SHALL, on accepted request with pc[1:0]!=0, enter RESP next cycle with err=1, inst=0, no memory access.
REQ-014 SHALL, on accepted aligned request hitting the line, enter RESP next cycle (1-cycle latency), inst = pc[2] ? line[63:32] : line[31:0].
REQ-015 SHALL, on miss, enter AR with lb_ar_addr_o = {pc[63:3],3'b000}, ar_valid held high and addr stable until ar_ready.
REQ-016 SHALL, in R, drive lb_r_ready_o high; on r_valid capture data; err=0 updates line and tag, sets valid; err=1 clears line valid, returns inst=0, err=1; then RESP.
REQ-017 SHALL in RESP hold inst_valid, inst, pc, err stable until inst_ready; on handshake return to IDLE.
REQ-018 SHALL on lb_flush_i: RESP -> IDLE, output dropped same cycle; AR keeps ar_valid until accepted, sets drop flag; R sets drop flag; dropped response still fills line if err=0, then IDLE without RESP.
REQ-019 SHALL ignore lb_flush_i in IDLE; flush and r_valid in same R cycle behave as flush-then-drop.
REQ-020 SHALL keep line contents unaffected by flush.

Reset
REQ-021 SHALL on lb_rst_n_i low, immediately: state IDLE, line valid 0, drop flag 0, all valid/ready outputs 0, data/addr/pc outputs 0.
REQ-022 SHALL abandon any in-flight memory transaction on reset mid-operation; IRAM reset together.

Configuration
REQ-023 SHALL honour macro LB_LINE_BUF_EN: defined -> line hit path active; undefined -> every aligned request misses, line register not built, memory read per request.

Structure
REQ-024 SHALL take DataBus_WIDTH, InstBus_WIDTH, RestEnable and state encodings from shared defines.v.
REQ-025 SHALL be one module; no sub-module required.

Verification
REQ-026 Reset, then req pc=0x80000000, ar_ready=1, r_data=0x00000013_00100093 after 2 cycles -> ar_addr=0x80000000, inst=0x00100093, inst_valid held until ready.
REQ-027 Next req pc=0x80000004 -> no ar_valid, inst=0x00000013 one cycle later (macro defined); with macro undefined -> new ar_valid.
REQ-028 req pc=0x80000002 -> no memory access, inst_err=1, inst=0.
REQ-029 Miss, ar_ready held low 3 cycles, flush in cycle 2 -> ar_valid/addr stable until accept, response consumed, no inst_valid, return IDLE.
REQ-030 Miss with r_err=1 -> inst_err=1, inst=0; same pc re-requested -> new memory read.
